// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for decode, and follows redirects from the branch/jump logic.
module instr_fetch_unit (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] link_pc,
   output logic [15:0] fetch_count,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] instr_q;
   logic [31:0] link_pc_q;
   logic [15:0] fetch_cnt_q;

   logic        load_instr;
   logic        count_en;
   logic [31:0] redirect_aligned;
   logic [31:0] pc_plus4;

   assign redirect_aligned = {redirect_pc[31:2], 2'b00};
   assign pc_plus4         = pc_q + 32'd4;

   // Handshakes: memory side is req/ack (imem_req held with a stable address
   // until imem_ack); decode side is valid/ready, a word transfers on any
   // edge where instr_valid and instr_ready are both 1.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      kill_d       = kill_q;
      load_instr   = 1'b0;
      count_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack) begin
               if (kill_q || redirect_valid) begin
                  // The returned word belongs to a stale path; drop it and re-issue.
                  pc_d   = redirect_valid ? redirect_aligned : pending_pc_q;
                  kill_d = 1'b0;
               end else begin
                  load_instr = 1'b1;
                  state_d    = ST_VALID;
               end
            end else if (redirect_valid) begin
               kill_d       = 1'b1;
               pending_pc_d = redirect_aligned;
            end
         end
         ST_VALID: begin
            if (redirect_valid) begin
               pc_d     = redirect_aligned;
               count_en = instr_ready;
               state_d  = ST_REQ;
            end else if (instr_ready) begin
               pc_d     = pc_plus4;
               count_en = 1'b1;
               state_d  = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         pending_pc_q <= '0;
         kill_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         kill_q       <= kill_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q   <= '0;
         link_pc_q <= '0;
      end else if (load_instr) begin
         instr_q   <= imem_rdata;
         link_pc_q <= pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
      end else if (count_en) begin
         fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
   end

   assign imem_req    = (state_q == ST_REQ);
   assign imem_addr   = {pc_q[31:2], 2'b00};
   assign instr_valid = (state_q == ST_VALID);
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign link_pc     = link_pc_q;
   assign fetch_count = fetch_cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch transactions plus
// hand-written kill, wrap and asynchronous-reset sequences.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] link_pc;
   logic [15:0] fetch_count;
   logic [1:0]  dbg_state;

   int pass_cnt = 0;
   int total_cnt = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr          (instr),
      .opcode         (opcode),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .link_pc        (link_pc),
      .fetch_count    (fetch_count),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1)
         check("req_valid_exclusive", 32'(imem_req & instr_valid), 32'd0);
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] rdata;
      int          ack_dly;
      int          hold;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] exp_addr;
      logic [5:0]  exp_op;
      logic [31:0] exp_link;
      logic [31:0] exp_next;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk_vec(input logic [31:0] rdata, input int ack_dly, input int hold,
                                   input logic ready, input logic redir, input logic [31:0] rpc,
                                   input logic [31:0] exp_addr, input logic [5:0] exp_op,
                                   input logic [31:0] exp_link, input logic [31:0] exp_next,
                                   input logic [15:0] exp_cnt);
      vec_t v;
      v.rdata = rdata; v.ack_dly = ack_dly; v.hold = hold; v.ready = ready;
      v.redir = redir; v.rpc = rpc; v.exp_addr = exp_addr; v.exp_op = exp_op;
      v.exp_link = exp_link; v.exp_next = exp_next; v.exp_cnt = exp_cnt;
      return v;
   endfunction

   // ---------------- driver tasks (entered and left just after a negedge) ----------------
   task automatic wait_req(input string name);
      for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
      check({name, "_req_seen"}, 32'(imem_req), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      wait_req(name);
      check({name, "_addr"}, imem_addr, v.exp_addr);
      repeat (v.ack_dly) @(negedge clk);
      check({name, "_addr_hold"}, imem_addr, v.exp_addr);
      imem_ack = 1'b1; imem_rdata = v.rdata;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = '0;
      check({name, "_valid"}, 32'(instr_valid), 32'd1);
      check({name, "_req_low"}, 32'(imem_req), 32'd0);
      check({name, "_instr"}, instr, v.rdata);
      check({name, "_opcode"}, 32'(opcode), 32'(v.exp_op));
      check({name, "_link"}, link_pc, v.exp_link);
      if (v.hold > 0) begin
         repeat (v.hold) @(negedge clk);
         check({name, "_hold_instr"}, instr, v.rdata);
         check({name, "_hold_opcode"}, 32'(opcode), 32'(v.exp_op));
         check({name, "_hold_link"}, link_pc, v.exp_link);
         check({name, "_hold_req"}, 32'(imem_req), 32'd0);
         check({name, "_hold_valid"}, 32'(instr_valid), 32'd1);
         check({name, "_hold_cnt"}, 32'(fetch_count), 32'(16'(v.exp_cnt - {15'd0, v.ready})));
      end
      instr_ready = v.ready; redirect_valid = v.redir; redirect_pc = v.rpc;
      @(negedge clk);
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      check({name, "_after_valid"}, 32'(instr_valid), 32'd0);
      check({name, "_after_req"}, 32'(imem_req), 32'd1);
      check({name, "_next_addr"}, imem_addr, v.exp_next);
      check({name, "_cnt"}, 32'(fetch_count), 32'(v.exp_cnt));
   endtask

   // Ack and redirect in the same REQ cycle: word dropped, new address issued.
   task automatic ack_with_redirect(input string name, input logic [31:0] cur, input logic [31:0] rpc,
                                    input logic [31:0] exp_next, input logic [15:0] exp_cnt);
      wait_req(name);
      check({name, "_addr"}, imem_addr, cur);
      imem_ack = 1'b1; imem_rdata = 32'h8C000000;
      redirect_valid = 1'b1; redirect_pc = rpc;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0;
      check({name, "_valid"}, 32'(instr_valid), 32'd0);
      check({name, "_req"}, 32'(imem_req), 32'd1);
      check({name, "_next_addr"}, imem_addr, exp_next);
      check({name, "_cnt"}, 32'(fetch_count), 32'(exp_cnt));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_req"}, 32'(imem_req), 32'd0);
      check({name, "_valid"}, 32'(instr_valid), 32'd0);
      check({name, "_addr"}, imem_addr, 32'd0);
      check({name, "_instr"}, instr, 32'd0);
      check({name, "_opcode"}, 32'(opcode), 32'd0);
      check({name, "_link"}, link_pc, 32'd0);
      check({name, "_cnt"}, 32'(fetch_count), 32'd0);
   endtask

   task automatic release_and_restart(input string name, input logic ack_level);
      imem_ack = ack_level; imem_rdata = 32'hFFFFFFFF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check({name, "_idle_req"}, 32'(imem_req), 32'd0);
      check({name, "_idle_valid"}, 32'(instr_valid), 32'd0);
      @(negedge clk);
      check({name, "_req_cycle2"}, 32'(imem_req), 32'd1);
      check({name, "_addr_cycle2"}, imem_addr, 32'd0);
      check({name, "_ack_ignored"}, instr, 32'd0);
      check({name, "_no_valid"}, 32'(instr_valid), 32'd0);
      imem_ack = 1'b0; imem_rdata = '0;
   endtask

   // ---------------- test ----------------
   initial begin
      vecs[0] = mk_vec(32'h8C080004, 1, 0, 1'b1, 1'b0, 32'h0,   32'h000, 6'h23, 32'h004, 32'h004, 16'd1);
      vecs[1] = mk_vec(32'h012A4020, 0, 5, 1'b1, 1'b0, 32'h0,   32'h004, 6'h00, 32'h008, 32'h008, 16'd2);
      vecs[2] = mk_vec(32'h11090003, 0, 0, 1'b1, 1'b0, 32'h0,   32'h008, 6'h04, 32'h00C, 32'h00C, 16'd3);
      vecs[3] = mk_vec(32'h15090004, 2, 0, 1'b1, 1'b0, 32'h0,   32'h00C, 6'h05, 32'h010, 32'h010, 16'd4);
      vecs[4] = mk_vec(32'h08000008, 0, 0, 1'b1, 1'b1, 32'h20,  32'h010, 6'h02, 32'h014, 32'h020, 16'd5);
      vecs[5] = mk_vec(32'h0C000040, 0, 1, 1'b1, 1'b1, 32'h103, 32'h020, 6'h03, 32'h024, 32'h100, 16'd6);
      vecs[6] = mk_vec(32'h03E00008, 1, 0, 1'b1, 1'b1, 32'h24,  32'h100, 6'h00, 32'h104, 32'h024, 16'd7);
      vecs[7] = mk_vec(32'h10000005, 0, 2, 1'b0, 1'b1, 32'h200, 32'h024, 6'h04, 32'h028, 32'h200, 16'd7);
      vecs[8] = mk_vec(32'h8C090008, 2, 0, 1'b1, 1'b0, 32'h0,   32'h200, 6'h23, 32'h204, 32'h204, 16'd8);

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      check("rel_idle_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      check("rel_req_cycle2", 32'(imem_req), 32'd1);
      check("rel_addr_cycle2", imem_addr, 32'd0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Redirect while waiting on memory; the late word must be dropped.
      check("kill_start_addr", imem_addr, 32'h204);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0; redirect_pc = '0;
      check("kill_addr_hold1", imem_addr, 32'h204);
      check("kill_req1", 32'(imem_req), 32'd1);
      repeat (2) @(negedge clk);
      check("kill_addr_hold3", imem_addr, 32'h204);
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = '0;
      check("kill_no_valid", 32'(instr_valid), 32'd0);
      check("kill_new_addr", imem_addr, 32'h40);
      check("kill_instr_kept", instr, 32'h8C090008);
      @(negedge clk);
      check("kill_no_valid_late", 32'(instr_valid), 32'd0);
      run_vec(mk_vec(32'h20010001, 0, 0, 1'b1, 1'b0, 32'h0, 32'h040, 6'h08, 32'h044, 32'h044, 16'd9), "after_kill");

      ack_with_redirect("ackredir", 32'h44, 32'h83, 32'h80, 16'd9);
      ack_with_redirect("to_top", 32'h80, 32'hFFFFFFFF, 32'hFFFFFFFC, 16'd9);

      // Address and counter wrap on the same accept.
      imem_ack = 1'b1; imem_rdata = 32'hAC010000;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = '0;
      check("wrap_valid", 32'(instr_valid), 32'd1);
      check("wrap_link", link_pc, 32'h0);
      check("wrap_opcode", 32'(opcode), 32'h2B);
      dut.fetch_cnt_q = 16'hFFFF;
      @(negedge clk);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_cnt", 32'(fetch_count), 32'd0);
      check("wrap_req", 32'(imem_req), 32'd1);

      // Reset asserted while holding a word in VALID.
      imem_ack = 1'b1; imem_rdata = 32'h8C080004;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = '0;
      check("pre_rst_valid", 32'(instr_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_in_valid");
      @(negedge clk);
      release_and_restart("rst_valid", 1'b1);

      // Reset asserted while a request is outstanding at a nonzero address.
      run_vec(mk_vec(32'h012A4020, 0, 0, 1'b1, 1'b0, 32'h0, 32'h000, 6'h00, 32'h004, 32'h004, 16'd1), "pre_rst_req");
      check("pre_rst_req_addr", imem_addr, 32'h4);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_in_req");
      @(negedge clk);
      release_and_restart("rst_req", 1'b0);
      run_vec(mk_vec(32'h8C080004, 1, 0, 1'b1, 1'b0, 32'h0, 32'h000, 6'h23, 32'h004, 32'h004, 16'd1), "restart");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
